// File: rtl/alu_seq_fsm.sv
// alu_seq_fsm: sequential W-bit ALU with a valid/ready input, a registered
// result held under backpressure, a steppable/loadable op register and an
// iterative restoring divider for DIV/MOD with divide-by-zero flagging.
module alu_seq_fsm #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   ain,
  input  logic [W-1:0]   bin,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           s,
  input  logic           op_ld,
  input  logic [2:0]     op_in,
  output logic [2:0]     op_cur,
  output logic [2*W-1:0] out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           dz,
  output logic           busy
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_MOD = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t         r_state;
  logic [2:0]     r_op;
  logic           r_s_q;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_b;
  logic           r_is_mod;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_out;
  logic           r_out_valid;
  logic           r_dz;
  logic           r_busy;
  logic           r_in_ready;

  logic [2*W-1:0] w_a2, w_b2, w_res;
  logic [W:0]     w_sub;
  logic           w_dz, w_div_start, w_accept;
  logic [W:0]     w_rem_sh;
  logic           w_ge;
  logic [W-1:0]   w_rem_sub, w_rem_next, w_quo_next;

  assign w_a2     = {{W{1'b0}}, ain};
  assign w_b2     = {{W{1'b0}}, bin};
  assign w_sub    = {1'b0, ain} - {1'b0, bin};
  assign w_accept = in_valid && r_in_ready;

  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor when it fits. The difference is below the divisor whenever
  // it is kept, so W bits of it suffice.
  assign w_rem_sh   = {r_rem, r_quo[W-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[W-1:0] - r_b;
  assign w_rem_next = w_ge ? w_rem_sub : w_rem_sh[W-1:0];
  assign w_quo_next = {r_quo[W-2:0], w_ge};

  // Single-cycle results, including the divide-by-zero fallbacks.
  always_comb begin
    w_res       = '0;
    w_dz        = 1'b0;
    w_div_start = 1'b0;
    case (r_op)
      OP_ADD: w_res = w_a2 + w_b2;
      OP_SUB: w_res = {{(W-1){1'b0}}, w_sub};
      OP_MUL: w_res = w_a2 * w_b2;
      OP_MOD: begin
        w_res       = w_a2;
        w_dz        = (bin == '0);
        w_div_start = (bin != '0);
      end
      OP_DIV: begin
        w_res       = {{W{1'b0}}, {W{1'b1}}};
        w_dz        = (bin == '0);
        w_div_start = (bin != '0);
      end
      OP_AND: w_res = {{W{1'b0}}, ain & bin};
      OP_OR:  w_res = {{W{1'b0}}, ain | bin};
      OP_XOR: w_res = {{W{1'b0}}, ain ^ bin};
      default: w_res = '0;
    endcase
  end

  // Op register: direct load wins over an s rising edge; frozen outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= '0;
      r_s_q <= 1'b0;
    end else begin
      r_s_q <= s;
      if (r_state == IDLE) begin
        if (op_ld)             r_op <= op_in;
        else if (s && !r_s_q)  r_op <= r_op + 3'd1;
      end
    end
  end

  // Main FSM with registered outputs; in_ready is a pure state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_dz        <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_rem       <= '0;
      r_quo       <= '0;
      r_b         <= '0;
      r_is_mod    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (w_div_start) begin
              r_state  <= DIVIDE;
              r_busy   <= 1'b1;
              r_rem    <= '0;
              r_quo    <= ain;
              r_b      <= bin;
              r_is_mod <= (r_op == OP_MOD);
              r_cnt    <= '0;
            end else begin
              r_state     <= DONE;
              r_out       <= w_res;
              r_dz        <= w_dz;
              r_out_valid <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_dz        <= 1'b0;
            r_out       <= r_is_mod ? {{W{1'b0}}, w_rem_next}
                                    : {{W{1'b0}}, w_quo_next};
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign op_cur    = r_op;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign dz        = r_dz;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Directed bench for alu_seq_fsm (W=8): table of single transactions plus
// hand-written sequences for op stepping, backpressure and reset mid-divide.
module tb_alu_seq_fsm;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, s, op_ld, out_valid, out_ready, dz, busy;
  logic [W-1:0]   ain, bin;
  logic [2:0]     op_in, op_cur;
  logic [2*W-1:0] out;

  int checks = 0;
  int failures = 0;

  alu_seq_fsm #(.W(W)) dut (
    .clk(clk), .rst(rst), .ain(ain), .bin(bin), .in_valid(in_valid),
    .in_ready(in_ready), .s(s), .op_ld(op_ld), .op_in(op_in), .op_cur(op_cur),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .dz(dz), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    logic        exp_dz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  // advance one clock; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic load_op(input logic [2:0] op);
    op_ld = 1'b1; op_in = op;
    step();
    op_ld = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int cyc, busyc;
    load_op(vecs[idx].op);
    check($sformatf("v%0d_op", idx), 32'(op_cur), 32'(vecs[idx].op));
    ain = vecs[idx].a; bin = vecs[idx].b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 1; busyc = 0;
    while (!out_valid && cyc < 40) begin
      if (busy) busyc++;
      step();
      cyc++;
    end
    check($sformatf("v%0d_lat", idx), 32'(cyc), 32'(vecs[idx].lat));
    check($sformatf("v%0d_out", idx), 32'(out), 32'(vecs[idx].exp));
    check($sformatf("v%0d_dz", idx), 32'(dz), 32'(vecs[idx].exp_dz));
    check($sformatf("v%0d_busycyc", idx), 32'(busyc), 32'(vecs[idx].lat - 1));
    check($sformatf("v%0d_busy_done", idx), 32'(busy), 32'd0);
    step();  // handshake (out_ready=1)
    check($sformatf("v%0d_ov_clr", idx), 32'(out_valid), 32'd0);
    check($sformatf("v%0d_rdy_back", idx), 32'(in_ready), 32'd1);
  endtask

  initial begin
    int ovc;
    vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1};
    vecs[1]  = '{3'd1, 8'd5,   8'd9,   16'h01FC, 1'b0, 1};
    vecs[2]  = '{3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1};
    vecs[3]  = '{3'd4, 8'd200, 8'd7,   16'h001C, 1'b0, 9};
    vecs[4]  = '{3'd3, 8'd200, 8'd7,   16'h0004, 1'b0, 9};
    vecs[5]  = '{3'd4, 8'd13,  8'd0,   16'h00FF, 1'b1, 1};
    vecs[6]  = '{3'd3, 8'd13,  8'd0,   16'h000D, 1'b1, 1};
    vecs[7]  = '{3'd5, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1};
    vecs[8]  = '{3'd6, 8'hF0,  8'h3C,  16'h00FC, 1'b0, 1};
    vecs[9]  = '{3'd7, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1};
    vecs[10] = '{3'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 1};
    vecs[11] = '{3'd1, 8'd9,   8'd5,   16'h0004, 1'b0, 1};
    vecs[12] = '{3'd4, 8'd255, 8'd1,   16'h00FF, 1'b0, 9};
    vecs[13] = '{3'd3, 8'd6,   8'd7,   16'h0006, 1'b0, 9};

    rst = 1'b1; in_valid = 1'b0; s = 1'b0; op_ld = 1'b0; op_in = '0;
    ain = '0; bin = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // reset state
    check("rst_out", 32'(out), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_op", 32'(op_cur), 32'd0);

    // 9 s pulses wrap to op 1
    for (int i = 0; i < 9; i++) begin
      s = 1'b1; step();
      s = 1'b0; step();
    end
    check("s9_wrap", 32'(op_cur), 32'd1);

    // s held high advances once
    s = 1'b1;
    for (int i = 0; i < 5; i++) step();
    s = 1'b0; step();
    check("s_held", 32'(op_cur), 32'd2);

    // op_ld beats a simultaneous s edge
    s = 1'b1; op_ld = 1'b1; op_in = 3'd6;
    step();
    s = 1'b0; op_ld = 1'b0;
    check("ld_prio", 32'(op_cur), 32'd6);
    step();

    // accept in the same cycle as an op load uses the old op (OR)
    ain = 8'hF0; bin = 8'h3C; in_valid = 1'b1; op_ld = 1'b1; op_in = 3'd7;
    step();
    in_valid = 1'b0; op_ld = 1'b0;
    check("same_cyc_op_new", 32'(op_cur), 32'd7);
    check("same_cyc_ov", 32'(out_valid), 32'd1);
    check("same_cyc_out_old_op", 32'(out), 32'h00FC);
    step();

    // table-driven transactions
    for (int i = 0; i < 14; i++) run_vec(i);

    // backpressure: AND held in DONE while out_ready is low
    load_op(3'd5);
    ain = 8'hF0; bin = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_out", i), 32'(out), 32'h0030);
      check($sformatf("bp%0d_ov", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_rdy", i), 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    check("bp_last_ov", 32'(out_valid), 32'd1);
    step();
    check("bp_ov_clr", 32'(out_valid), 32'd0);
    check("bp_rdy_back", 32'(in_ready), 32'd1);

    // reset in flight at cycle 4 of DIV 255/3
    load_op(3'd4);
    ain = 8'd255; bin = 8'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("rif_busy_c4", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rif_rdy", 32'(in_ready), 32'd1);
    check("rif_ov", 32'(out_valid), 32'd0);
    check("rif_busy", 32'(busy), 32'd0);
    check("rif_op", 32'(op_cur), 32'd0);
    ovc = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) ovc++;
      step();
    end
    check("rif_no_result", 32'(ovc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq_fsm.md
# alu_seq_fsm

Parametrised sequential ALU that supersedes the 8-bit four-mode ALU. W-bit operands enter through a valid/ready handshake, and the output is registered with backpressure. The block supports eight operations, including an iterative restoring divider for DIV/MOD with divide-by-zero flagging. The operation can be stepped by the legacy `s` pulse or loaded directly. It sits between the operand source and the result consumer in the datapath.

## Interface
- `W`, 8: operand width in bits; must be ≥ 2. Result width is 2W.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ain` input W: operand A, unsigned.
- `bin` input W: operand B, unsigned.
- `in_valid` input 1: operands and op offered this cycle.
- `in_ready` output 1: block accepts operands this cycle.
- `s` input 1: op-step request; a rising edge advances the op.
- `op_ld` input 1: load `op_in` into the op register.
- `op_in` input 3: directly loaded op code.
- `op_cur` output 3: current op register.
- `out` output 2W: result, registered.
- `out_valid` output 1: `out` holds a valid result.
- `out_ready` input 1: consumer takes the result.
- `dz` output 1: divide by zero flag, qualified by `out_valid`.
- `busy` output 1: high while the divider iterates.

## Operation
- Op codes: 0 ADD, 1 SUB, 2 MUL, 3 MOD, 4 DIV, 5 AND, 6 OR, 7 XOR.
- Op register updates only in IDLE.
  - `op_ld` = 1 loads `op_in`, and takes priority over `s`.
  - Otherwise a rising edge of `s` (`s`=1 while registered `s_q`=0) sets op ← op+1 mod 8.
  - `s` held high advances the op exactly once.
- Accept condition: `in_valid && in_ready`. The accept captures `ain`, `bin` and the pre-update `op_cur`. An op change in the same cycle affects only later transactions.
- State machine:
  - IDLE: `in_ready`=1. On accept, go to DIVIDE for DIV/MOD with `bin`≠0; otherwise go to DONE with the result computed from the captured operands.
  - DIVIDE: restoring division, one quotient bit per cycle, MSB first, W cycles, `busy`=1. After the last iteration, load the result and go to DONE.
  - DONE: `out_valid`=1, `in_ready`=0. `out` and `dz` stay stable. When `out_ready`=1, go to IDLE and clear `out_valid`.
- Result formats (unsigned, zero-extended to 2W):
  - ADD: W+1-bit sum.
  - SUB: W+1-bit `{borrow, a-b mod 2^W}`; the borrow bit is 1 when a<b.
  - MUL: full 2W product.
  - DIV: quotient in bits [W-1:0].
  - MOD: remainder in bits [W-1:0].
  - AND/OR/XOR: bitwise result in bits [W-1:0].
- Divide by zero (DIV/MOD with `bin`=0): skip DIVIDE and go straight to DONE with `dz`=1.
  - DIV returns all-ones in [W-1:0].
  - MOD returns `ain`.
  - `dz`=0 for every other result.
- No overlapping transactions: the next accept happens no earlier than the cycle after the DONE handshake.

## Timing
- Reset values: `out`=0, `out_valid`=0, `dz`=0, `busy`=0, `in_ready`=1, `op_cur`=0, `s_q`=0, state IDLE.
- `rst` aborts any operation, including mid-DIVIDE or DONE. The pending result is discarded and never presented.
- Latency is counted from the accept edge at cycle 0 to `out_valid` high:
  - Single-cycle ops and divide-by-zero: `out_valid` high at cycle 1.
  - DIV/MOD with `bin`≠0: `busy` high during cycles 1..W, `out_valid` high at cycle W+1.
- DONE with `out_ready`=1: `out_valid` is high for exactly one cycle, and `in_ready` returns to 1 on the following cycle.
- `in_ready` is a registered state decode and never combinationally depends on `out_ready`.

## Test plan
- W=8, ADD 200+100; SUB 5−9; MUL 255×255, each with `out_ready`=1:
  - ADD gives `out`=0x012C at cycle 1.
  - SUB gives `out`=0x01FC.
  - MUL gives `out`=0xFE01, with `dz`=0 throughout.
- DIV and MOD of 200 by 7:
  - DIV gives `out`=0x001C, `out_valid` at cycle 9, `busy` high during cycles 1..8.
  - MOD gives `out`=0x0004.
- 13 by 0: DIV gives `out`=0x00FF with `dz`=1 at cycle 1. MOD gives `out`=0x000D with `dz`=1, and `busy` never asserts.
- Op stepping and loading:
  - 9 `s` pulses after reset give `op_cur`=1 (wrap).
  - `s` held high for 5 cycles advances the op once.
  - `op_ld`=1 with `op_in`=6 and an `s` edge in the same cycle gives `op_cur`=6.
  - An accept in the same cycle as an op change uses the old op.
- Backpressure: AND 0xF0,0x3C with `out_ready` low for 3 cycles keeps `out`=0x0030 and `out_valid`=1 stable with `in_ready`=0. `in_ready` returns to 1 the cycle after the handshake.
- Reset in flight: `rst` pulsed at cycle 4 of DIV 255/3. Next cycle shows state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0 and `op_cur`=0, and `out_valid` never asserts for the aborted job.
